plt_cfg_loader: RTL and testbench

Configuration loader for the programmable logic tile (PLT): the writer side of the PLT configuration interface. It accepts a parallel configuration word and shifts it serially into the PLT on `config_in` while holding the PLT in configuration mode. It then switches the PLT to test mode, compares the PLT's `scan_out` against the word it sent, and releases the PLT into usage mode with a pass/fail flag. It sits between the system/control logic and one PLT instance, and drives that instance's `mode`, `config_in` and `scan_enable`.

---
 rtl/plt_cfg_loader.sv | 117 +++++++++++
 tb/tb_plt_cfg_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/plt_cfg_loader.sv
// plt_cfg_loader: writer side of the PLT configuration interface.
// Takes a parallel configuration word, shifts it LSB first into the PLT
// while the PLT is in configure mode, switches to test mode for two cycles,
// checks the PLT's scan_out against what was sent, then releases the PLT
// into usage mode and reports the result on done/error.
//
// Handshake: start is a one-cycle request. It is accepted only in IDLE or
// RUN; cfg_word is captured on that same edge. busy is high from acceptance
// until done. done is a one-cycle pulse. error is sticky until the next
// accepted start. A start in SHIFT or VERIFY is dropped, never queued.
module plt_cfg_loader #(
  parameter int N     = 8,
  parameter int CFG_W = 4 * (N - 1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic [CFG_W-1:0] scan_out,
  output logic [1:0]       mode,
  output logic             config_in,
  output logic             scan_enable,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int CW = $clog2(CFG_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CFG_W - 1);

  localparam logic [1:0] MODE_CFG  = 2'b00;
  localparam logic [1:0] MODE_TEST = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    VERIFY = 2'd2,
    RUN    = 2'd3
  } state_t;

  // state is left as a plain named register so checkers can bind to it
  state_t           state;
  logic [CFG_W-1:0] shift_reg;
  logic [CFG_W-1:0] shadow;
  logic [CW-1:0]    bit_cnt;
  logic             verify_second;

  // Single-process FSM: all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state         <= IDLE;
      shift_reg     <= '0;
      shadow        <= '0;
      bit_cnt       <= '0;
      verify_second <= 1'b0;
      mode          <= MODE_CFG;
      config_in     <= 1'b0;
      scan_enable   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          // done is high for only the first RUN cycle
          done <= 1'b0;
          if (start) begin
            shift_reg     <= cfg_word;
            shadow        <= cfg_word;
            bit_cnt       <= '0;
            verify_second <= 1'b0;
            // bit 0 goes out in the very first SHIFT cycle
            config_in     <= cfg_word[0];
            mode          <= MODE_CFG;
            scan_enable   <= 1'b0;
            busy          <= 1'b1;
            error         <= 1'b0;
            state         <= SHIFT;
          end
        end

        SHIFT: begin
          shift_reg <= {1'b0, shift_reg[CFG_W-1:1]};
          bit_cnt   <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            mode          <= MODE_TEST;
            scan_enable   <= 1'b1;
            config_in     <= 1'b0;
            verify_second <= 1'b0;
            state         <= VERIFY;
          end else begin
            // present the bit that becomes shift_reg[0] after this edge
            config_in <= shift_reg[1];
          end
        end

        VERIFY: begin
          if (!verify_second) begin
            // first cycle gives the scan chain time to settle
            verify_second <= 1'b1;
          end else begin
            error       <= (scan_out != shadow);
            done        <= 1'b1;
            mode        <= MODE_RUN;
            scan_enable <= 1'b0;
            busy        <= 1'b0;
            state       <= RUN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plt_cfg_loader.sv
// Bench for plt_cfg_loader: a PLT shift-chain model feeds scan_out, a
// negedge monitor scoreboards config_in bits and done/error results, and a
// driver walks a vector table plus hand-written corner sequences.
module tb_plt_cfg_loader;

  localparam int N     = 8;
  localparam int CFG_W = 4 * (N - 1);

  // clock / reset
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [CFG_W-1:0] cfg_word = '0;
  logic [CFG_W-1:0] scan_out;
  logic [1:0]       mode;
  logic             config_in;
  logic             scan_enable;
  logic             busy;
  logic             done;
  logic             error;

  plt_cfg_loader #(.N(N), .CFG_W(CFG_W)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .start       (start),
    .cfg_word    (cfg_word),
    .scan_out    (scan_out),
    .mode        (mode),
    .config_in   (config_in),
    .scan_enable (scan_enable),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // PLT model: chain captures config_in on each edge while in configure mode
  logic [CFG_W-1:0] chain = '0;
  logic             ovr_en = 1'b0;
  logic [CFG_W-1:0] ovr_val = '0;
  always @(posedge clk) if (mode == 2'b00) chain <= {config_in, chain[CFG_W-1:1]};
  assign scan_out = ovr_en ? ovr_val : chain;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // scoreboard
  typedef struct {
    logic        err;
    int unsigned cyc;
  } res_t;

  logic [0:0] exp_q[$];
  res_t       res_q[$];
  int         nchk = 0;
  int         nerr = 0;
  int         vcnt = 0;
  int         done_cnt = 0;
  logic       prev_done = 1'b0;

  task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: samples DUT on the falling edge
  always @(negedge clk) begin
    logic [0:0] eb;
    res_t r;
    if (clear_n) begin
      if (busy && mode == 2'b00) begin
        if (exp_q.size() == 0) chk(1'b0, "extra_shift_bit", 32'(config_in), 32'hx);
        else begin
          eb = exp_q.pop_front();
          chk(config_in == eb, "config_in_bit", 32'(config_in), 32'(eb));
        end
        chk(scan_enable == 1'b0, "shift_scan_enable", 32'(scan_enable), 32'd0);
      end
      if (mode == 2'b10) begin
        chk(scan_enable == 1'b1 && config_in == 1'b0 && busy == 1'b1, "verify_outputs",
            32'({scan_enable, config_in, busy}), 32'b101);
        vcnt++;
      end
      if (done) begin
        chk(!prev_done, "done_single_cycle", 32'(prev_done), 32'd0);
        if (res_q.size() == 0) chk(1'b0, "unexpected_done", 32'(done), 32'd0);
        else begin
          r = res_q.pop_front();
          chk(error == r.err, "done_error", 32'(error), 32'(r.err));
          chk(cyc_cnt == r.cyc, "done_latency", cyc_cnt, r.cyc);
          chk(mode == 2'b01 && busy == 1'b0, "done_mode_busy", 32'({mode, busy}), 32'b010);
          chk(vcnt == 2, "verify_cycles", 32'(vcnt), 32'd2);
          chk(exp_q.size() == 0, "bits_left", 32'(exp_q.size()), 32'd0);
        end
        vcnt = 0;
        done_cnt++;
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // driver tasks: all driving happens 1 time unit after the falling edge
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic start_load(input logic [CFG_W-1:0] word, input logic oe,
                            input logic [CFG_W-1:0] ov, input logic exp_err);
    ovr_en   = oe;
    ovr_val  = ov;
    cfg_word = word;
    start    = 1'b1;
    for (int k = 0; k < CFG_W; k++) exp_q.push_back(word[k]);
    res_q.push_back('{err: exp_err, cyc: cyc_cnt + CFG_W + 3});
    cyc();
    start    = 1'b0;
    cfg_word = $urandom();
    chk(busy == 1'b1 && error == 1'b0 && mode == 2'b00, "accept_state",
        32'({busy, error, mode}), 32'b1000);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (res_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk(res_q.size() == 0, "done_timeout", 32'(res_q.size()), 32'd0);
    res_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [CFG_W-1:0] word;
    logic             ovr;
    logic [CFG_W-1:0] ovr_val;
    logic             exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0;
    vecs[0] = '{word: 28'h5A3_CF01, ovr: 1'b0, ovr_val: 28'h0,        exp_err: 1'b0};
    vecs[1] = '{word: 28'h5A3_CF01, ovr: 1'b1, ovr_val: 28'h5A3_CF00, exp_err: 1'b1};
    vecs[2] = '{word: 28'h5A3_CF01, ovr: 1'b0, ovr_val: 28'h0,        exp_err: 1'b0};
    vecs[3] = '{word: 28'hFFF_FFFF, ovr: 1'b0, ovr_val: 28'h0,        exp_err: 1'b0};
    vecs[4] = '{word: CFG_W'($urandom_range(32'h0FFF_FFFF, 0)), ovr: 1'b0, ovr_val: 28'h0, exp_err: 1'b0};
    vecs[5] = '{word: 28'h000_0000, ovr: 1'b1, ovr_val: 28'h000_0001, exp_err: 1'b1};

    // reset values
    repeat (2) cyc();
    chk(mode == 2'b00, "reset_mode", 32'(mode), 32'd0);
    chk(config_in == 1'b0, "reset_config_in", 32'(config_in), 32'd0);
    chk(scan_enable == 1'b0, "reset_scan_enable", 32'(scan_enable), 32'd0);
    chk(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
    chk(done == 1'b0, "reset_done", 32'(done), 32'd0);
    chk(error == 1'b0, "reset_error", 32'(error), 32'd0);
    clear_n = 1'b1;
    repeat (2) cyc();

    // vector table, run back to back
    for (int i = 0; i < 6; i++) begin
      start_load(vecs[i].word, vecs[i].ovr, vecs[i].ovr_val, vecs[i].exp_err);
      wait_done(40);
    end
    repeat (3) cyc();
    chk(error == vecs[5].exp_err, "error_sticky", 32'(error), 32'(vecs[5].exp_err));
    chk(mode == 2'b01 && done == 1'b0 && busy == 1'b0, "run_idle_outputs",
        32'({mode, done, busy}), 32'b0100);

    // start during SHIFT is ignored
    d0 = done_cnt;
    start_load(28'hFFF_FFFF, 1'b0, '0, 1'b0);
    repeat (10) cyc();
    cfg_word = '0;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
    wait_done(40);
    repeat (4) cyc();
    chk(done_cnt == d0 + 1, "ignored_start_single_done", 32'(done_cnt - d0), 32'd1);

    // reset in the middle of SHIFT
    start_load(28'h5A3_CF01, 1'b0, '0, 1'b0);
    repeat (15) cyc();
    clear_n = 1'b0;
    #1;
    chk({mode, config_in, scan_enable, busy, done, error} == 7'b0, "reset_mid_outputs",
        32'({mode, config_in, scan_enable, busy, done, error}), 32'd0);
    exp_q.delete();
    res_q.delete();
    vcnt = 0;
    d0 = done_cnt;
    repeat (2) cyc();
    clear_n = 1'b1;
    repeat (35) cyc();
    chk(done_cnt == d0, "no_done_after_reset", 32'(done_cnt - d0), 32'd0);
    chk(mode == 2'b00 && busy == 1'b0, "idle_after_reset", 32'({mode, busy}), 32'd0);
    start_load(28'h123_4567, 1'b0, '0, 1'b0);
    wait_done(40);
    chk(done_cnt == d0 + 1, "fresh_load_done", 32'(done_cnt - d0), 32'd1);

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
